// File: rtl/spis_avmm_bridge_n.sv
// spis_avmm_bridge_n: moves DWord bursts between the SPI-slave register buffers
// and one of NUM_CH Avalon-MM master channels, one outstanding access at a time.
// Optional feature macro: SPIS_AVMM_TIMEOUT_EN (aborts a stalled handshake after
// TMO_CYC cycles with err_code 2). Without it the bridge waits indefinitely.
module spis_avmm_bridge_n #(
  parameter int NUM_CH     = 3,
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 32,
  parameter int BLEN_W     = 8,
  parameter int BUF_AW     = 16,
  parameter int WRBUF_BASE = 'h0200,
  parameter int RDBUF_BASE = 'h1000,
  parameter int TMO_CYC    = 1023,
  localparam int SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       s_avmm_clk,
  input  logic                       s_avmm_rst_n,
  input  logic                       cmd_vld,
  input  logic                       cmd_rdnwr,
  input  logic [SEL_W-1:0]           cmd_sel,
  input  logic [ADDR_W-1:0]          cmd_offset,
  input  logic [BLEN_W-1:0]          cmd_brstlen,
  output logic [NUM_CH*ADDR_W-1:0]   m_addr,
  output logic [NUM_CH*DATA_W/8-1:0] m_byte_en,
  output logic [NUM_CH-1:0]          m_write,
  output logic [NUM_CH-1:0]          m_read,
  output logic [NUM_CH*DATA_W-1:0]   m_wdata,
  input  logic [NUM_CH*DATA_W-1:0]   m_rdata,
  input  logic [NUM_CH-1:0]          m_rdatavld,
  input  logic [NUM_CH-1:0]          m_waitreq,
  output logic [BUF_AW-1:0]          buf_addr,
  output logic                       buf_rd,
  input  logic [DATA_W-1:0]          buf_rdata,
  output logic                       buf_wr,
  output logic [DATA_W-1:0]          buf_wdata,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [1:0]                 err_code
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE, CMD, WR_FETCH, WR_LATCH, WR_REQ, RD_REQ, RD_WAIT, DONE
  } state_t;

  state_t              state_q, state_d;
  logic                cmd_vld_q;
  logic                rdnwr_q, rdnwr_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BLEN_W-1:0]   count_q, count_d;
  logic [BUF_AW-1:0]   buf_addr_q, buf_addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;

  logic                start;
  logic                wr_c, rd_c, buf_rd_c, buf_wr_c, advance;
  logic                last_word, tmo_hit;
  logic [NUM_CH-1:0]   chan_hit;
  logic                sel_waitreq, sel_rdatavld;
  logic [DATA_W-1:0]   sel_rdata;
  logic [DATA_W-1:0]   rdata_masked [NUM_CH];

  assign start     = cmd_vld & ~cmd_vld_q;
  assign last_word = (count_q == BLEN_W'(1));

  // Per-channel decode: only the captured channel sees strobes, the rest stay at zero.
  // An out-of-range select matches no channel, so it can never reach a slave.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign chan_hit[gi]                  = (sel_q == SEL_W'(gi));
    assign m_write[gi]                   = wr_c & chan_hit[gi];
    assign m_read[gi]                    = rd_c & chan_hit[gi];
    assign m_addr[gi*ADDR_W +: ADDR_W]   = (m_write[gi] | m_read[gi]) ? addr_q : '0;
    assign m_byte_en[gi*BE_W +: BE_W]    = (m_write[gi] | m_read[gi]) ? '1 : '0;
    assign m_wdata[gi*DATA_W +: DATA_W]  = m_write[gi] ? wdata_q : '0;
    assign rdata_masked[gi]              = chan_hit[gi] ? m_rdata[gi*DATA_W +: DATA_W] : '0;
  end

  assign sel_waitreq  = |(m_waitreq & chan_hit);
  assign sel_rdatavld = |(m_rdatavld & chan_hit);

  // Read-data mux: OR of the masked channels, only the selected one is non-zero.
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_CH; i++) sel_rdata = sel_rdata | rdata_masked[i];
  end

`ifdef SPIS_AVMM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_hit = (tmo_cnt_q == TMO_W'(TMO_CYC));

  // Stall counter: restarts on every state change or completed word, counts while waiting on a slave.
  always_comb begin
    tmo_cnt_d = '0;
    if (((state_q == WR_REQ) || (state_q == RD_REQ) || (state_q == RD_WAIT)) &&
        (state_d == state_q) && !advance)
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
  end

  // Stall counter register.
  always_ff @(posedge s_avmm_clk or negedge s_avmm_rst_n) begin
    if (!s_avmm_rst_n) tmo_cnt_q <= '0;
    else               tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Next-state and datapath updates for the burst sequencer.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    rdnwr_d    = rdnwr_q;
    addr_d     = addr_q;
    count_d    = count_q;
    buf_addr_d = buf_addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    wr_c       = 1'b0;
    rd_c       = 1'b0;
    buf_rd_c   = 1'b0;
    buf_wr_c   = 1'b0;
    advance    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sel_d      = cmd_sel;
          rdnwr_d    = cmd_rdnwr;
          addr_d     = cmd_offset;
          count_d    = cmd_brstlen;
          err_d      = 1'b0;
          err_code_d = 2'd0;
          state_d    = CMD;
        end
      end
      CMD: begin
        if (int'(sel_q) >= NUM_CH) begin
          err_d      = 1'b1;
          err_code_d = 2'd1;
          state_d    = DONE;
        end else if (count_q == '0) begin
          state_d = DONE;
        end else if (rdnwr_q) begin
          buf_addr_d = BUF_AW'(RDBUF_BASE);
          state_d    = RD_REQ;
        end else begin
          buf_addr_d = BUF_AW'(WRBUF_BASE);
          state_d    = WR_FETCH;
        end
      end
      WR_FETCH: begin
        buf_rd_c = 1'b1;
        state_d  = WR_LATCH;
      end
      WR_LATCH: begin
        wdata_d = buf_rdata;
        state_d = WR_REQ;
      end
      WR_REQ: begin
        if (tmo_hit) begin
          err_d      = 1'b1;
          err_code_d = 2'd2;
          state_d    = DONE;
        end else begin
          wr_c = 1'b1;
          if (!sel_waitreq) begin
            advance = 1'b1;
            state_d = last_word ? DONE : WR_FETCH;
          end
        end
      end
      RD_REQ: begin
        if (tmo_hit) begin
          err_d      = 1'b1;
          err_code_d = 2'd2;
          state_d    = DONE;
        end else begin
          rd_c = 1'b1;
          if (!sel_waitreq) begin
            if (sel_rdatavld) begin
              buf_wr_c = 1'b1;
              advance  = 1'b1;
              state_d  = last_word ? DONE : RD_REQ;
            end else begin
              state_d = RD_WAIT;
            end
          end
        end
      end
      RD_WAIT: begin
        if (tmo_hit) begin
          err_d      = 1'b1;
          err_code_d = 2'd2;
          state_d    = DONE;
        end else if (sel_rdatavld) begin
          buf_wr_c = 1'b1;
          advance  = 1'b1;
          state_d  = last_word ? DONE : RD_REQ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (advance) begin
      addr_d     = addr_q + ADDR_W'(BE_W);
      buf_addr_d = buf_addr_q + BUF_AW'(1);
      count_d    = count_q - BLEN_W'(1);
    end
  end

  // State and datapath registers; reset aborts any burst without a done pulse.
  always_ff @(posedge s_avmm_clk or negedge s_avmm_rst_n) begin
    if (!s_avmm_rst_n) begin
      state_q    <= IDLE;
      cmd_vld_q  <= 1'b0;
      rdnwr_q    <= 1'b0;
      sel_q      <= '0;
      addr_q     <= '0;
      count_q    <= '0;
      buf_addr_q <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      cmd_vld_q  <= cmd_vld;
      rdnwr_q    <= rdnwr_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      buf_addr_q <= buf_addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign buf_addr  = buf_addr_q;
  assign buf_rd    = buf_rd_c;
  assign buf_wr    = buf_wr_c;
  assign buf_wdata = buf_wr_c ? sel_rdata : '0;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_spis_avmm_bridge_n.sv
// Directed bench for spis_avmm_bridge_n (3 channels, 32-bit data, 17-bit address).
module tb_spis_avmm_bridge_n;

  localparam int NCH = 3;
  localparam int AW  = 17;
  localparam int DW  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              cmd_vld, cmd_rdnwr;
  logic [1:0]        cmd_sel;
  logic [AW-1:0]     cmd_offset;
  logic [7:0]        cmd_brstlen;
  logic [NCH*AW-1:0] m_addr;
  logic [NCH*4-1:0]  m_byte_en;
  logic [NCH-1:0]    m_write, m_read, m_rdatavld, m_waitreq;
  logic [NCH*DW-1:0] m_wdata, m_rdata;
  logic [15:0]       buf_addr;
  logic              buf_rd, buf_wr;
  logic [DW-1:0]     buf_rdata, buf_wdata;
  logic              busy, done, err;
  logic [1:0]        err_code;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mem [0:1023];

  spis_avmm_bridge_n #(.TMO_CYC(15)) dut (
    .s_avmm_clk(clk), .s_avmm_rst_n(rst_n),
    .cmd_vld(cmd_vld), .cmd_rdnwr(cmd_rdnwr), .cmd_sel(cmd_sel),
    .cmd_offset(cmd_offset), .cmd_brstlen(cmd_brstlen),
    .m_addr(m_addr), .m_byte_en(m_byte_en), .m_write(m_write), .m_read(m_read),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_rdatavld(m_rdatavld), .m_waitreq(m_waitreq),
    .buf_addr(buf_addr), .buf_rd(buf_rd), .buf_rdata(buf_rdata),
    .buf_wr(buf_wr), .buf_wdata(buf_wdata),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  // Write-buffer model: data one cycle after the read strobe.
  always @(posedge clk) if (buf_rd) buf_rdata <= mem[buf_addr[9:0]];

  function automatic logic [AW-1:0] ch_addr(input int ch);
    return m_addr[ch*AW +: AW];
  endfunction
  function automatic logic [DW-1:0] ch_wdata(input int ch);
    return m_wdata[ch*DW +: DW];
  endfunction
  function automatic logic [3:0] ch_be(input int ch);
    return m_byte_en[ch*4 +: 4];
  endfunction

  task automatic start_cmd(input logic rdnwr, input logic [1:0] sel,
                           input logic [AW-1:0] off, input logic [7:0] len);
    @(negedge clk);
    cmd_rdnwr = rdnwr; cmd_sel = sel; cmd_offset = off; cmd_brstlen = len;
    cmd_vld = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_vld = 0; cmd_rdnwr = 0; cmd_sel = 0; cmd_offset = 0; cmd_brstlen = 0;
    m_rdata = '0; m_rdatavld = '0; m_waitreq = '0;
    repeat (3) @(negedge clk);
    checks++; if ({m_write, m_read} !== '0) begin failures++; $display("FAIL reset_strobes got=%h want=0", {m_write, m_read}); end
    checks++; if (m_addr !== '0) begin failures++; $display("FAIL reset_addr got=%h want=0", m_addr); end
    checks++; if ({m_byte_en, m_wdata} !== '0) begin failures++; $display("FAIL reset_wdata_be got=%h want=0", {m_byte_en, m_wdata}); end
    checks++; if ({buf_addr, buf_rd, buf_wr, buf_wdata} !== '0) begin failures++; $display("FAIL reset_buf got=%h want=0", {buf_addr, buf_rd, buf_wr, buf_wdata}); end
    checks++; if ({busy, done, err, err_code} !== 5'b0) begin failures++; $display("FAIL reset_status got=%b want=00000", {busy, done, err, err_code}); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_release_busy got=%b want=0", busy); end
  endtask

  task automatic test_write_burst();
    logic [AW-1:0] exp_addr [0:2];
    logic [DW-1:0] exp_data [0:2];
    int n = 0, nrd = 0, other = 0, dcnt = 0;
    exp_addr = '{17'h00100, 17'h00104, 17'h00108};
    exp_data = '{32'hA5A5_0001, 32'hB6B6_0002, 32'hC7C7_0003};
    mem[512] = exp_data[0]; mem[513] = exp_data[1]; mem[514] = exp_data[2];
    m_waitreq = '0;
    start_cmd(1'b0, 2'd1, 17'h00100, 8'd3);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk); cmd_vld = 1'b0; #1;
      if (buf_rd) begin
        checks++; if (buf_addr !== 16'h0200 + 16'(nrd)) begin failures++; $display("FAIL wr_buf_addr got=%h want=%h", buf_addr, 16'h0200 + 16'(nrd)); end
        nrd++;
      end
      if (m_write[1]) begin
        $display("wr ch=1 addr=%h data=%h be=%h", ch_addr(1), ch_wdata(1), ch_be(1));
        if (n < 3) begin
          checks++; if (ch_addr(1) !== exp_addr[n]) begin failures++; $display("FAIL wr_addr got=%h want=%h", ch_addr(1), exp_addr[n]); end
          checks++; if (ch_wdata(1) !== exp_data[n]) begin failures++; $display("FAIL wr_data got=%h want=%h", ch_wdata(1), exp_data[n]); end
          checks++; if (ch_be(1) !== 4'hF) begin failures++; $display("FAIL wr_byte_en got=%h want=f", ch_be(1)); end
        end
        n++;
      end
      if (m_write[0] | m_write[2] | (|m_read) | (ch_addr(0) != 0) | (ch_addr(2) != 0)) other++;
      if (done) dcnt++;
      if (dcnt > 0 && !busy) break;
    end
    checks++; if (n !== 3) begin failures++; $display("FAIL wr_count got=%0d want=3", n); end
    checks++; if (nrd !== 3) begin failures++; $display("FAIL wr_buf_reads got=%0d want=3", nrd); end
    checks++; if (other !== 0) begin failures++; $display("FAIL wr_other_ch got=%0d want=0", other); end
    checks++; if (dcnt !== 1) begin failures++; $display("FAIL wr_done got=%0d want=1", dcnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wr_busy_after got=%b want=0", busy); end
  endtask

  task automatic test_read_backpressure();
    logic [DW-1:0] exp_data [0:1];
    int hold = 0, pend = 0, n = 0, rcyc = 0, dcnt = 0, other = 0;
    exp_data = '{32'h1234_5678, 32'h9ABC_DEF0};
    start_cmd(1'b1, 2'd2, 17'h00040, 8'd2);
    for (int c = 0; c < 80; c++) begin
      @(negedge clk); cmd_vld = 1'b0; m_waitreq = '0; m_rdatavld = '0; m_rdata = '0; #1;
      if (m_read[2]) begin
        rcyc++;
        checks++; if (ch_addr(2) !== 17'h00040 + 17'(4 * n)) begin failures++; $display("FAIL rd_addr got=%h want=%h", ch_addr(2), 17'h00040 + 17'(4 * n)); end
        if (hold < 3) begin m_waitreq[2] = 1'b1; hold++; end
        else begin hold = 0; pend = 2; end
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin m_rdatavld[2] = 1'b1; m_rdata[2*DW +: DW] = exp_data[n < 2 ? n : 0]; end
      end
      #1;
      if (buf_wr) begin
        $display("bufwr addr=%h data=%h", buf_addr, buf_wdata);
        if (n < 2) begin
          checks++; if (buf_addr !== 16'h1000 + 16'(n)) begin failures++; $display("FAIL rd_buf_addr got=%h want=%h", buf_addr, 16'h1000 + 16'(n)); end
          checks++; if (buf_wdata !== exp_data[n]) begin failures++; $display("FAIL rd_buf_data got=%h want=%h", buf_wdata, exp_data[n]); end
        end
        n++;
      end
      if ((|m_write) | m_read[0] | m_read[1]) other++;
      if (done) dcnt++;
      if (dcnt > 0 && !busy) break;
    end
    checks++; if (n !== 2) begin failures++; $display("FAIL rd_count got=%0d want=2", n); end
    checks++; if (rcyc !== 8) begin failures++; $display("FAIL rd_req_cycles got=%0d want=8", rcyc); end
    checks++; if (other !== 0) begin failures++; $display("FAIL rd_other_ch got=%0d want=0", other); end
    checks++; if (dcnt !== 1) begin failures++; $display("FAIL rd_done got=%0d want=1", dcnt); end
  endtask

  task automatic test_read_same_cycle();
    logic [DW-1:0] exp_data [0:1];
    int first = -1, second = -1, done_at = -1, n = 0;
    exp_data = '{32'hCAFE_0000, 32'hCAFE_0001};
    start_cmd(1'b1, 2'd0, 17'h00080, 8'd2);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); cmd_vld = 1'b0; m_waitreq = '0; m_rdatavld = '0; m_rdata = '0; #1;
      if (m_read[0]) begin
        if (first < 0) first = c; else if (second < 0) second = c;
        m_rdatavld[0] = 1'b1; m_rdata[0 +: DW] = exp_data[n < 2 ? n : 0];
      end
      #1;
      if (buf_wr) begin
        $display("bufwr addr=%h data=%h", buf_addr, buf_wdata);
        if (n < 2) begin
          checks++; if (buf_wdata !== exp_data[n]) begin failures++; $display("FAIL fast_data got=%h want=%h", buf_wdata, exp_data[n]); end
          checks++; if (buf_addr !== 16'h1000 + 16'(n)) begin failures++; $display("FAIL fast_buf_addr got=%h want=%h", buf_addr, 16'h1000 + 16'(n)); end
        end
        n++;
      end
      if (done && done_at < 0) done_at = c;
      if (done_at >= 0 && !busy) break;
    end
    checks++; if (n !== 2) begin failures++; $display("FAIL fast_count got=%0d want=2", n); end
    checks++; if (second !== first + 1) begin failures++; $display("FAIL fast_skip_wait got=%0d want=%0d", second, first + 1); end
    checks++; if (done_at !== second + 1) begin failures++; $display("FAIL fast_done_cycle got=%0d want=%0d", done_at, second + 1); end
  endtask

  task automatic test_bad_channel();
    int strobes = 0, dcnt = 0;
    start_cmd(1'b0, 2'd3, 17'h00000, 8'd4);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); cmd_vld = 1'b0; #1;
      if ((|m_write) | (|m_read) | buf_rd | buf_wr) strobes++;
      if (done) dcnt++;
      if (dcnt > 0 && !busy) break;
    end
    $display("badch err=%b code=%0d", err, err_code);
    checks++; if (strobes !== 0) begin failures++; $display("FAIL badch_strobes got=%0d want=0", strobes); end
    checks++; if (dcnt !== 1) begin failures++; $display("FAIL badch_done got=%0d want=1", dcnt); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL badch_err got=%b want=1", err); end
    checks++; if (err_code !== 2'd1) begin failures++; $display("FAIL badch_code got=%0d want=1", err_code); end
    repeat (2) @(negedge clk);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL badch_sticky got=%b want=1", err); end
  endtask

  task automatic test_zero_len();
    int strobes = 0, dcnt = 0;
    start_cmd(1'b1, 2'd0, 17'h00010, 8'd0);
    @(negedge clk); cmd_vld = 1'b0; #1;
    checks++; if ({err, err_code} !== 3'b000) begin failures++; $display("FAIL zlen_err_cleared got=%b want=000", {err, err_code}); end
    for (int c = 0; c < 20; c++) begin
      if ((|m_write) | (|m_read) | buf_rd | buf_wr) strobes++;
      if (done) dcnt++;
      if (dcnt > 0 && !busy) break;
      @(negedge clk); #1;
    end
    $display("zlen done=%0d err=%b", dcnt, err);
    checks++; if (strobes !== 0) begin failures++; $display("FAIL zlen_strobes got=%0d want=0", strobes); end
    checks++; if (dcnt !== 1) begin failures++; $display("FAIL zlen_done got=%0d want=1", dcnt); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL zlen_err got=%b want=0", err); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_addr [0:1];
    logic [DW-1:0] exp_data [0:1];
    int n = 0;
    exp_addr = '{17'h1FFFC, 17'h00000};
    exp_data = '{32'h0BAD_F00D, 32'hFEED_BEEF};
    mem[512] = exp_data[0]; mem[513] = exp_data[1];
    m_waitreq = '0;
    start_cmd(1'b0, 2'd0, 17'h1FFFC, 8'd2);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); cmd_vld = 1'b0; #1;
      if (m_write[0]) begin
        $display("wr ch=0 addr=%h data=%h", ch_addr(0), ch_wdata(0));
        if (n < 2) begin
          checks++; if (ch_addr(0) !== exp_addr[n]) begin failures++; $display("FAIL wrap_addr got=%h want=%h", ch_addr(0), exp_addr[n]); end
          checks++; if (ch_wdata(0) !== exp_data[n]) begin failures++; $display("FAIL wrap_data got=%h want=%h", ch_wdata(0), exp_data[n]); end
        end
        n++;
      end
      if (done) break;
    end
    checks++; if (n !== 2) begin failures++; $display("FAIL wrap_count got=%0d want=2", n); end
  endtask

  task automatic test_reset_mid();
    int seen = 0, dcnt = 0, n = 0;
    m_waitreq = '0; m_waitreq[1] = 1'b1;
    start_cmd(1'b0, 2'd1, 17'h00300, 8'd3);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); cmd_vld = 1'b0; #1;
      if (m_write[1]) begin seen = 1; break; end
    end
    checks++; if (seen !== 1) begin failures++; $display("FAIL rstmid_reach_wrreq got=%0d want=1", seen); end
    rst_n = 1'b0; #1;
    checks++; if ({m_write, m_read, m_addr, m_wdata, m_byte_en} !== '0) begin failures++; $display("FAIL rstmid_avmm got=%h want=0", {m_write, m_read, m_addr}); end
    checks++; if ({busy, done, buf_rd, buf_wr, buf_addr} !== '0) begin failures++; $display("FAIL rstmid_status got=%h want=0", {busy, done, buf_rd, buf_wr, buf_addr}); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      if (done) dcnt++;
    end
    @(negedge clk); rst_n = 1'b1; m_waitreq = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      if (done) dcnt++;
    end
    checks++; if (dcnt !== 0) begin failures++; $display("FAIL rstmid_no_done got=%0d want=0", dcnt); end
    mem[512] = 32'h7777_1111;
    start_cmd(1'b0, 2'd2, 17'h00020, 8'd1);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); cmd_vld = 1'b0; #1;
      if (m_write[2]) begin
        $display("wr ch=2 addr=%h data=%h", ch_addr(2), ch_wdata(2));
        checks++; if ({ch_addr(2), ch_wdata(2)} !== {17'h00020, 32'h7777_1111}) begin failures++; $display("FAIL rstmid_after_wr got=%h want=%h", {ch_addr(2), ch_wdata(2)}, {17'h00020, 32'h7777_1111}); end
        n++;
      end
      if (done) dcnt++;
      if (dcnt > 0 && !busy) break;
    end
    checks++; if ({n, dcnt} !== {32'd1, 32'd1}) begin failures++; $display("FAIL rstmid_after_counts got=%0d/%0d want=1/1", n, dcnt); end
  endtask

`ifdef SPIS_AVMM_TIMEOUT_EN
  task automatic test_timeout();
    int rcyc = 0, dcnt = 0, wrs = 0;
    m_waitreq = '1;
    start_cmd(1'b1, 2'd0, 17'h00000, 8'd2);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk); cmd_vld = 1'b0; m_waitreq = '1; #1;
      if (m_read[0]) rcyc++;
      if (buf_wr) wrs++;
      if (done) dcnt++;
      if (dcnt > 0 && !busy) break;
    end
    m_waitreq = '0;
    $display("timeout read_cycles=%0d code=%0d", rcyc, err_code);
    checks++; if (rcyc !== 15) begin failures++; $display("FAIL tmo_read_cycles got=%0d want=15", rcyc); end
    checks++; if ({err, err_code} !== 3'b110) begin failures++; $display("FAIL tmo_err got=%b want=110", {err, err_code}); end
    checks++; if (dcnt !== 1) begin failures++; $display("FAIL tmo_done got=%0d want=1", dcnt); end
    checks++; if (wrs !== 0) begin failures++; $display("FAIL tmo_bufwr got=%0d want=0", wrs); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_burst();
    test_read_backpressure();
    test_read_same_cycle();
    test_bad_channel();
    test_zero_len();
    test_wrap();
    test_reset_mid();
`ifdef SPIS_AVMM_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
